// File: rtl/spi_segment_sequencer_if.sv
// Bundle between the segment sequencer, its segment memory, both drawing engines and the display bus.
// master = sequencer side, slave = memory/engines/host side.
interface spi_segment_sequencer_if #(
  parameter int AW = 4
);
  // host control and status
  logic          i_start;
  logic          i_abort;
  logic          o_busy;
  logic          o_done;
  // segment memory
  logic [AW-1:0] o_seg_addr;
  logic [35:0]   i_seg_data;
  // general line engine
  logic          o_line_start;
  logic [8:0]    o_line_x1;
  logic [8:0]    o_line_y1;
  logic [8:0]    o_line_x2;
  logic [8:0]    o_line_y2;
  logic          i_line_done;
  logic          i_line_mosi;
  logic          i_line_dc;
  logic          i_line_cs;
  // horizontal-span engine
  logic          o_hor_start;
  logic [8:0]    o_hor_x1;
  logic [8:0]    o_hor_x2;
  logic [8:0]    o_hor_y;
  logic          i_hor_done;
  logic          i_hor_mosi;
  logic          i_hor_dc;
  logic          i_hor_cs;
  // shared display bus
  logic          o_mosi;
  logic          o_dc;
  logic          o_cs;

  modport master (
    input  i_start, i_abort, i_seg_data,
    input  i_line_done, i_line_mosi, i_line_dc, i_line_cs,
    input  i_hor_done, i_hor_mosi, i_hor_dc, i_hor_cs,
    output o_busy, o_done, o_seg_addr,
    output o_line_start, o_line_x1, o_line_y1, o_line_x2, o_line_y2,
    output o_hor_start, o_hor_x1, o_hor_x2, o_hor_y,
    output o_mosi, o_dc, o_cs
  );

  modport slave (
    output i_start, i_abort, i_seg_data,
    output i_line_done, i_line_mosi, i_line_dc, i_line_cs,
    output i_hor_done, i_hor_mosi, i_hor_dc, i_hor_cs,
    input  o_busy, o_done, o_seg_addr,
    input  o_line_start, o_line_x1, o_line_y1, o_line_x2, o_line_y2,
    input  o_hor_start, o_hor_x1, o_hor_x2, o_hor_y,
    input  o_mosi, o_dc, o_cs
  );
endinterface

// File: rtl/spi_segment_sequencer.sv
// Walks segments 0..SEG_COUNT-1 from segment memory, hands each to the line or horizontal engine,
// waits for that engine's done and muxes its SPI outputs onto the display bus while it runs.
module spi_segment_sequencer #(
  parameter int SEG_COUNT = 15,
  parameter int AW        = 4
) (
  input logic                     i_clk,
  input logic                     i_rst,
  spi_segment_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, RUN, FIN} state_t;
  typedef enum logic {SEL_LINE, SEL_HOR} sel_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(SEG_COUNT - 1);

  state_t     state;
  sel_t       sel;
  logic [8:0] x1, y1, x2, y2;
  logic       sel_done;
  logic       start_high;

  assign x1 = bus.i_seg_data[35:27];
  assign y1 = bus.i_seg_data[26:18];
  assign x2 = bus.i_seg_data[17:9];
  assign y2 = bus.i_seg_data[8:0];

  assign sel_done   = (sel == SEL_HOR) ? bus.i_hor_done : bus.i_line_done;
  // a done seen alongside our own start pulse belongs to an older job
  assign start_high = bus.o_line_start | bus.o_hor_start;

  always_comb begin
    bus.o_mosi = 1'b0;
    bus.o_dc   = 1'b0;
    bus.o_cs   = 1'b1;
    if (state == RUN) begin
      if (sel == SEL_HOR) begin
        bus.o_mosi = bus.i_hor_mosi;
        bus.o_dc   = bus.i_hor_dc;
        bus.o_cs   = bus.i_hor_cs;
      end else begin
        bus.o_mosi = bus.i_line_mosi;
        bus.o_dc   = bus.i_line_dc;
        bus.o_cs   = bus.i_line_cs;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= IDLE;
      sel              <= SEL_LINE;
      bus.o_seg_addr   <= '0;
      bus.o_busy       <= 1'b0;
      bus.o_done       <= 1'b0;
      bus.o_line_start <= 1'b0;
      bus.o_line_x1    <= '0;
      bus.o_line_y1    <= '0;
      bus.o_line_x2    <= '0;
      bus.o_line_y2    <= '0;
      bus.o_hor_start  <= 1'b0;
      bus.o_hor_x1     <= '0;
      bus.o_hor_x2     <= '0;
      bus.o_hor_y      <= '0;
    end else begin
      bus.o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            bus.o_seg_addr <= '0;
            bus.o_busy     <= 1'b1;
            state          <= FETCH;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          if (y1 == y2) begin
            bus.o_hor_y     <= y1;
            bus.o_hor_x1    <= (x1 <= x2) ? x1 : x2;
            bus.o_hor_x2    <= (x1 <= x2) ? x2 : x1;
            bus.o_hor_start <= 1'b1;
            sel             <= SEL_HOR;
          end else begin
            bus.o_line_x1    <= x1;
            bus.o_line_y1    <= y1;
            bus.o_line_x2    <= x2;
            bus.o_line_y2    <= y2;
            bus.o_line_start <= 1'b1;
            sel              <= SEL_LINE;
          end
          state <= RUN;
        end
        RUN: begin
          bus.o_line_start <= 1'b0;
          bus.o_hor_start  <= 1'b0;
          if (!start_high && sel_done) begin
            if (bus.o_seg_addr == LAST_ADDR) begin
              bus.o_done <= 1'b1;
              state      <= FIN;
            end else begin
              bus.o_seg_addr <= bus.o_seg_addr + AW'(1);
              state          <= FETCH;
            end
          end
        end
        FIN: begin
          bus.o_busy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // abort wins over everything, including a done arriving this cycle
      if (bus.i_abort && state != IDLE) begin
        state            <= IDLE;
        bus.o_busy       <= 1'b0;
        bus.o_done       <= 1'b0;
        bus.o_line_start <= 1'b0;
        bus.o_hor_start  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_segment_sequencer.sv
// Directed bench for spi_segment_sequencer: pentagon table, horizontal ordering, stray done,
// abort, async reset and cycle-exact start/done timing against stub engines.
module tb_spi_segment_sequencer;
  localparam int AW        = 4;
  localparam int SEG_COUNT = 5;
  localparam int ENG_LAT   = 10;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  spi_segment_sequencer_if #(.AW(AW)) bus ();

  spi_segment_sequencer #(.SEG_COUNT(SEG_COUNT), .AW(AW)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  logic [35:0] mem [0:15];
  always @(posedge i_clk) bus.i_seg_data <= mem[bus.o_seg_addr];

  int         checks = 0;
  int         errors = 0;
  int         line_cnt, hor_cnt, nstart, ndone;
  bit         auto_eng;
  logic [4:0] ord;
  int         hq_x1[$];
  int         hq_x2[$];
  int         hq_y[$];

  function automatic logic [35:0] seg(input int a, input int b, input int c, input int d);
    logic [8:0] pa, pb, pc, pd;
    pa = a[8:0]; pb = b[8:0]; pc = c[8:0]; pd = d[8:0];
    return {pa, pb, pc, pd};
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one clock, then the stub engines and start/done monitor
  task automatic tick();
    @(posedge i_clk);
    #1;
    if (auto_eng) begin
      bus.i_line_done = 1'b0;
      bus.i_hor_done  = 1'b0;
      if (line_cnt != 0) begin
        line_cnt--;
        if (line_cnt == 0) bus.i_line_done = 1'b1;
      end
      if (hor_cnt != 0) begin
        hor_cnt--;
        if (hor_cnt == 0) bus.i_hor_done = 1'b1;
      end
    end
    if (bus.o_line_start) begin
      line_cnt = ENG_LAT;
      ord      = {ord[3:0], 1'b0};
      nstart++;
    end
    if (bus.o_hor_start) begin
      hor_cnt = ENG_LAT;
      ord     = {ord[3:0], 1'b1};
      nstart++;
      hq_x1.push_back(int'(bus.o_hor_x1));
      hq_x2.push_back(int'(bus.o_hor_x2));
      hq_y.push_back(int'(bus.o_hor_y));
    end
    if (bus.o_done) ndone++;
  endtask

  task automatic run_drawing(input string tag);
    bit done_seen;
    done_seen = 1'b0;
    ndone = 0; nstart = 0; ord = '0; line_cnt = 0; hor_cnt = 0;
    hq_x1.delete(); hq_x2.delete(); hq_y.delete();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (bus.o_done) begin
        check_eq({tag, "_busy_at_done"}, int'(bus.o_busy), 1);
        done_seen = 1'b1;
      end else if (done_seen) begin
        check_eq({tag, "_idle_after_done"}, int'(bus.o_busy), 0);
        break;
      end
    end
    check_eq({tag, "_done_seen"}, int'(done_seen), 1);
    check_eq({tag, "_done_count"}, ndone, 1);
    check_eq({tag, "_start_count"}, nstart, SEG_COUNT);
  endtask

  task automatic load_pentagon();
    mem[0] = seg(120, 46, 225, 122);
    mem[1] = seg(225, 122, 185, 245);
    mem[2] = seg(185, 245, 55, 245);
    mem[3] = seg(55, 245, 15, 122);
    mem[4] = seg(15, 122, 120, 46);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    load_pentagon();
    i_rst = 1'b1;
    bus.i_start = 1'b0; bus.i_abort = 1'b0;
    bus.i_line_done = 1'b0; bus.i_line_mosi = 1'b1; bus.i_line_dc = 1'b0; bus.i_line_cs = 1'b0;
    bus.i_hor_done  = 1'b0; bus.i_hor_mosi  = 1'b0; bus.i_hor_dc  = 1'b1; bus.i_hor_cs  = 1'b0;
    auto_eng = 1'b0; line_cnt = 0; hor_cnt = 0; nstart = 0; ndone = 0; ord = '0;

    repeat (2) @(posedge i_clk);
    #1;
    check_eq("rst_busy", int'(bus.o_busy), 0);
    check_eq("rst_done", int'(bus.o_done), 0);
    check_eq("rst_cs", int'(bus.o_cs), 1);
    check_eq("rst_mosi", int'(bus.o_mosi), 0);
    check_eq("rst_dc", int'(bus.o_dc), 0);
    check_eq("rst_addr", int'(bus.o_seg_addr), 0);
    check_eq("rst_starts", int'({bus.o_line_start, bus.o_hor_start}), 0);
    check_eq("rst_coord", int'(bus.o_line_x1 | bus.o_hor_x2 | bus.o_hor_y), 0);
    i_rst = 1'b0;
    tick();

    // cycle-exact start pulse and done handling, engines driven by hand
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check_eq("e0_busy", int'(bus.o_busy), 1);
    check_eq("e0_no_start", int'(bus.o_line_start), 0);
    tick();
    check_eq("e1_no_start", int'(bus.o_line_start), 0);
    tick();
    check_eq("e2_line_start", int'(bus.o_line_start), 1);
    check_eq("e2_hor_start", int'(bus.o_hor_start), 0);
    check_eq("seg0_x1", int'(bus.o_line_x1), 120);
    check_eq("seg0_y2", int'(bus.o_line_y2), 122);
    check_eq("run_bus_mosi", int'(bus.o_mosi), 1);
    check_eq("run_bus_dc", int'(bus.o_dc), 0);
    check_eq("run_bus_cs", int'(bus.o_cs), 0);
    bus.i_line_done = 1'b1;
    tick();
    bus.i_line_done = 1'b0;
    check_eq("start_pulse_width", int'(bus.o_line_start), 0);
    check_eq("done_in_start_cycle_ignored", int'(bus.o_seg_addr), 0);
    bus.i_hor_done = 1'b1;
    tick();
    bus.i_hor_done = 1'b0;
    tick();
    check_eq("stray_hor_done_addr", int'(bus.o_seg_addr), 0);
    check_eq("stray_hor_done_cs", int'(bus.o_cs), 0);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check_eq("start_while_busy_addr", int'(bus.o_seg_addr), 0);
    check_eq("start_while_busy_busy", int'(bus.o_busy), 1);
    bus.i_line_done = 1'b1;
    tick();
    bus.i_line_done = 1'b0;
    check_eq("ek_addr_inc", int'(bus.o_seg_addr), 1);
    check_eq("ek_bus_idle_cs", int'(bus.o_cs), 1);
    check_eq("ek_bus_idle_mosi", int'(bus.o_mosi), 0);
    tick();
    check_eq("ek1_no_start", int'(bus.o_line_start), 0);
    tick();
    check_eq("ek2_line_start", int'(bus.o_line_start), 1);
    check_eq("seg1_x1", int'(bus.o_line_x1), 225);

    // abort during the second segment
    ndone = 0;
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    check_eq("abort_busy", int'(bus.o_busy), 0);
    check_eq("abort_cs", int'(bus.o_cs), 1);
    check_eq("abort_start", int'(bus.o_line_start), 0);
    repeat (3) tick();
    check_eq("abort_no_done", ndone, 0);
    check_eq("abort_stays_idle", int'(bus.o_busy), 0);

    // restart from segment 0, then async reset in RUN
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check_eq("restart_addr", int'(bus.o_seg_addr), 0);
    check_eq("restart_busy", int'(bus.o_busy), 1);
    repeat (2) tick();
    check_eq("restart_line_start", int'(bus.o_line_start), 1);
    check_eq("restart_seg0_x1", int'(bus.o_line_x1), 120);
    check_eq("restart_run_cs", int'(bus.o_cs), 0);
    #2;
    i_rst = 1'b1;
    #1;
    check_eq("arst_busy", int'(bus.o_busy), 0);
    check_eq("arst_cs", int'(bus.o_cs), 1);
    check_eq("arst_start", int'(bus.o_line_start), 0);
    check_eq("arst_coord", int'(bus.o_line_x1), 0);
    check_eq("arst_mosi", int'(bus.o_mosi), 0);
    tick();
    i_rst = 1'b0;
    tick();

    // full pentagon with stub engines
    auto_eng = 1'b1;
    run_drawing("pent");
    check_eq("pent_engine_order", int'(ord), 5'b00100);
    check_eq("pent_hor_count", hq_x1.size(), 1);
    if (hq_x1.size() >= 1) begin
      check_eq("pent_hor_x1", hq_x1[0], 55);
      check_eq("pent_hor_x2", hq_x2[0], 185);
      check_eq("pent_hor_y", hq_y[0], 245);
    end

    // horizontal ordering, single point, vertical line, x beyond 8 bits
    mem[0] = seg(200, 30, 10, 30);
    mem[1] = seg(7, 7, 7, 7);
    mem[2] = seg(0, 0, 8, 3);
    mem[3] = seg(9, 1, 9, 200);
    mem[4] = seg(300, 5, 2, 5);
    tick();
    run_drawing("hor");
    check_eq("hor_engine_order", int'(ord), 5'b11001);
    check_eq("hor_count", hq_x1.size(), 3);
    if (hq_x1.size() >= 3) begin
      check_eq("hor_swap_x1", hq_x1[0], 10);
      check_eq("hor_swap_x2", hq_x2[0], 200);
      check_eq("hor_swap_y", hq_y[0], 30);
      check_eq("point_x1", hq_x1[1], 7);
      check_eq("point_x2", hq_x2[1], 7);
      check_eq("point_y", hq_y[1], 7);
      check_eq("wide_x1", hq_x1[2], 2);
      check_eq("wide_x2", hq_x2[2], 300);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
